// File: rtl/sevenseg_scan_driver_if.sv
// Load/display bundle for the seven-segment scan driver: word load strobe in, multiplexed
// anode/segment drive and frame marker out.
interface sevenseg_scan_driver_if;
  logic        load;
  logic [11:0] left_word;
  logic [11:0] right_word;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  modport master (
    output load, left_word, right_word, dp_mask,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  load, left_word, right_word, dp_mask,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Scans two 12-bit words in octal across an 8-digit multiplexed seven-segment display.
// Optional macro SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits within each word.
module sevenseg_scan_driver #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 4
) (
  input logic                   clock,
  input logic                   resetN,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned CntW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_TICKS - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_TICKS);

  function automatic logic [6:0] octal_pattern(input logic [2:0] d);
    logic [6:0] p;
    unique case (d)
      3'd0: p = 7'h3F;
      3'd1: p = 7'h06;
      3'd2: p = 7'h5B;
      3'd3: p = 7'h4F;
      3'd4: p = 7'h66;
      3'd5: p = 7'h6D;
      3'd6: p = 7'h7D;
      3'd7: p = 7'h07;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            terminal;
  logic            frame_start;

  logic [11:0] pend_left_q, pend_left_d, pend_right_q, pend_right_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic [11:0] sh_left_q, sh_left_d, sh_right_q, sh_right_d;
  logic [7:0]  sh_dp_q, sh_dp_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [11:0] word_sel;
  logic [11:0] word_shift;
  logic [1:0]  pos;
  logic        blank_slot;
  logic        lz_blank;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_left_q  <= '0;
      pend_right_q <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      sh_left_q    <= '0;
      sh_right_q   <= '0;
      sh_dp_q      <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      sh_left_q    <= sh_left_d;
      sh_right_q   <= sh_right_d;
      sh_dp_q      <= sh_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  always_comb begin
    terminal    = (cnt_q == CntLast);
    cnt_d       = terminal ? '0 : cnt_q + CntW'(1);
    idx_d       = terminal ? idx_q + 3'd1 : idx_q;
    frame_start = terminal && (idx_q == 3'd7);
  end

  // Shadow only moves at a frame boundary so a frame never mixes old and new words.
  always_comb begin
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    sh_left_d    = sh_left_q;
    sh_right_d   = sh_right_q;
    sh_dp_d      = sh_dp_q;
    if (bus.load) begin
      pend_left_d  = bus.left_word;
      pend_right_d = bus.right_word;
      pend_dp_d    = bus.dp_mask;
      if (frame_start) begin
        sh_left_d   = bus.left_word;
        sh_right_d  = bus.right_word;
        sh_dp_d     = bus.dp_mask;
        pend_flag_d = 1'b0;
      end else begin
        pend_flag_d = 1'b1;
      end
    end else if (frame_start && pend_flag_q) begin
      sh_left_d   = pend_left_q;
      sh_right_d  = pend_right_q;
      sh_dp_d     = pend_dp_q;
      pend_flag_d = 1'b0;
    end
  end

  always_comb begin
    word_sel   = idx_q[2] ? sh_left_q : sh_right_q;
    pos        = idx_q[1:0];
    word_shift = word_sel >> (4'(pos) * 4'd3);
    blank_slot = (cnt_q < BlankEnd);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    lz_blank   = (pos != 2'd0) && (word_shift == 12'd0);
`else
    lz_blank   = 1'b0;
`endif
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank_slot) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = lz_blank ? 7'h7F : ~octal_pattern(word_shift[2:0]);
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start;

endmodule
